rr_output_arbiter: RTL and testbench

Round-robin, packet-locking arbiter for one output port of the 5-port mesh router. It takes the five per-input-port requests for this output and grants the output to exactly one input at a time. The grant is held for the whole wormhole packet, from head flit to tail flit. Its one-hot `select` drives the crossbar mux for this output, replacing the fixed-priority, unregistered selector. There is one instance per output port.

---
 rtl/rr_output_arbiter_if.sv | 31 +++
 rtl/rr_output_arbiter.sv | 115 +++++++++++
 tb/tb_rr_output_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rr_output_arbiter_if.sv
// rr_output_arbiter_if: groups the request/flow-control inputs and the
// grant/status outputs of one output-port arbiter.
//   req       : per-input valid flit routed to this output
//   tail      : per-input "presented flit is a tail"
//   out_ready : downstream can accept one flit this cycle
//   select    : one-hot owner of the output (all-zero when idle)
//   busy      : output locked to an owner
//   fire      : a flit transfers this cycle
//   grant_ptr : round-robin start index
// slave is the arbiter side, master is the router/testbench side.
interface rr_output_arbiter_if #(
   parameter int NPORTS = 5
);
   logic [NPORTS-1:0] req;
   logic [NPORTS-1:0] tail;
   logic              out_ready;
   logic [NPORTS-1:0] select;
   logic              busy;
   logic              fire;
   logic [2:0]        grant_ptr;

   modport slave (
      input  req, tail, out_ready,
      output select, busy, fire, grant_ptr
   );

   modport master (
      output req, tail, out_ready,
      input  select, busy, fire, grant_ptr
   );
endinterface

// File: rtl/rr_output_arbiter.sv
// rr_output_arbiter: round-robin, packet-locking arbiter for one output port
// of the mesh router. The grant is held from head flit to tail flit; the
// registered one-hot select drives the crossbar mux for this output.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : rr_output_arbiter_if.slave (req/tail/out_ready in,
//         select/busy/fire/grant_ptr out)
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | no owner, select = 0, arbitrate on any request
// S_LOCKED | select holds the owner until its tail transfers
module rr_output_arbiter #(
   parameter int NPORTS = 5
) (
   input  logic               clk,
   input  logic               rst,
   rr_output_arbiter_if.slave bus
);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t            state_q, state_d;
   logic [NPORTS-1:0] select_q, select_d;
   logic [2:0]        ptr_q, ptr_d;
   logic              fire;
   logic              tail_fire;
   int                owner;
   int                next_start;

   // First set bit of vec at or after start, wrapping. Ranking each bit by
   // its distance from start keeps all bit selects on constant loop indices.
   function automatic logic [NPORTS-1:0] rr_pick(input logic [NPORTS-1:0] vec,
                                                 input int start);
      logic [NPORTS-1:0] pick;
      int                best_d;
      int                best;
      int                d;
      pick   = '0;
      best_d = NPORTS;
      best   = 0;
      for (int i = 0; i < NPORTS; i++) begin
         d = (i + NPORTS - start) % NPORTS;
         if (vec[i] && (d < best_d)) begin
            best_d = d;
            best   = i;
         end
      end
      for (int i = 0; i < NPORTS; i++) begin
         pick[i] = (best_d < NPORTS) && (i == best);
      end
      return pick;
   endfunction

   function automatic int onehot_idx(input logic [NPORTS-1:0] vec);
      int idx;
      idx = 0;
      for (int i = 0; i < NPORTS; i++) begin
         if (vec[i]) idx = i;
      end
      return idx;
   endfunction

   always_comb begin
      state_d    = state_q;
      select_d   = select_q;
      ptr_d      = ptr_q;
      owner      = onehot_idx(select_q);
      next_start = (owner + 1) % NPORTS;
      // select_q is zero in idle, so no separate state term is needed here.
      fire       = (state_q == S_LOCKED) && (|(bus.req & select_q)) && bus.out_ready;
      tail_fire  = fire && (|(bus.tail & select_q));

      unique case (state_q)
         S_IDLE: begin
            if (|bus.req) begin
               select_d = rr_pick(bus.req, int'(ptr_q));
               state_d  = S_LOCKED;
            end
         end
         S_LOCKED: begin
            if (tail_fire) begin
               // Hand over in the same cycle so back-to-back packets
               // see no idle bubble; the old owner is excluded.
               ptr_d    = 3'(next_start);
               select_d = rr_pick(bus.req & ~select_q, next_start);
               state_d  = (|(bus.req & ~select_q)) ? S_LOCKED : S_IDLE;
            end
         end
         default: begin
            state_d  = S_IDLE;
            select_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         select_q <= '0;
         ptr_q    <= '0;
      end else begin
         state_q  <= state_d;
         select_q <= select_d;
         ptr_q    <= ptr_d;
      end
   end

   assign bus.select    = select_q;
   assign bus.busy      = (state_q == S_LOCKED);
   assign bus.fire      = fire;
   assign bus.grant_ptr = ptr_q;

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Testbench for rr_output_arbiter: table of per-cycle input/expected-output
// records plus hand-written sequences for combinational fire and fairness.
module tb_rr_output_arbiter;

   logic clk;
   logic rst;

   rr_output_arbiter_if #(.NPORTS(5)) bus ();

   rr_output_arbiter #(.NPORTS(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [4:0] req;
      logic [4:0] tail;
      logic       ordy;
      logic       chk;
      logic [4:0] sel;
      logic       busy;
      logic       fire;
      logic [2:0] ptr;
   } vec_t;

   typedef struct {
      logic       chk;
      logic [4:0] sel;
      logic       busy;
      logic       fire;
      logic [2:0] ptr;
      string      tag;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_pass;
   int   n_total;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic void add(input logic r, input logic [4:0] rq, input logic [4:0] tl,
                               input logic o, input logic c, input logic [4:0] s,
                               input logic b, input logic f, input logic [2:0] p);
      vec_t v;
      v.rst = r; v.req = rq; v.tail = tl; v.ordy = o; v.chk = c;
      v.sel = s; v.busy = b; v.fire = f; v.ptr = p;
      vecs.push_back(v);
   endfunction

   // Drive one cycle at the falling edge, queue its expectation, then
   // compare shortly after while outputs are stable.
   task automatic step(input logic r, input logic [4:0] rq, input logic [4:0] tl,
                       input logic o, input logic c, input logic [4:0] s,
                       input logic b, input logic f, input logic [2:0] p,
                       input string tag);
      exp_t e;
      @(negedge clk);
      rst           = r;
      bus.req       = rq;
      bus.tail      = tl;
      bus.out_ready = o;
      e.chk = c; e.sel = s; e.busy = b; e.fire = f; e.ptr = p; e.tag = tag;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      if (e.chk) begin
         check({e.tag, ".select"},    {3'b0, bus.select},    {3'b0, e.sel});
         check({e.tag, ".busy"},      {7'b0, bus.busy},      {7'b0, e.busy});
         check({e.tag, ".fire"},      {7'b0, bus.fire},      {7'b0, e.fire});
         check({e.tag, ".grant_ptr"}, {5'b0, bus.grant_ptr}, {5'b0, e.ptr});
      end
   endtask

   initial begin
      logic [4:0] oh;
      int         p;
      n_pass        = 0;
      n_total       = 0;
      rst           = 1'b1;
      bus.req       = '0;
      bus.tail      = '0;
      bus.out_ready = 1'b1;

      //   rst req       tail      rdy chk sel       bsy fir ptr
      // reset with all requesting, then release
      add(1, 5'b11111, 5'b00000, 1, 0, 5'b00000, 0, 0, 0);
      add(1, 5'b11111, 5'b00000, 1, 1, 5'b00000, 0, 0, 0);
      add(0, 5'b11111, 5'b00000, 1, 1, 5'b00000, 0, 0, 0);
      add(0, 5'b00000, 5'b00000, 1, 1, 5'b00001, 1, 0, 0);
      add(0, 5'b00001, 5'b00001, 1, 1, 5'b00001, 1, 1, 0);
      add(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 1);
      // 3-flit packet from port 2
      add(0, 5'b00100, 5'b00000, 1, 1, 5'b00000, 0, 0, 1);
      add(0, 5'b00100, 5'b00000, 1, 1, 5'b00100, 1, 1, 1);
      add(0, 5'b00100, 5'b00000, 1, 1, 5'b00100, 1, 1, 1);
      add(0, 5'b00100, 5'b00100, 1, 1, 5'b00100, 1, 1, 1);
      add(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 3);
      // round-robin over single-flit packets
      add(1, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 3);
      add(0, 5'b11111, 5'b11111, 1, 1, 5'b00000, 0, 0, 0);
      add(0, 5'b11111, 5'b11111, 1, 1, 5'b00001, 1, 1, 0);
      add(0, 5'b11111, 5'b11111, 1, 1, 5'b00010, 1, 1, 1);
      add(0, 5'b11111, 5'b11111, 1, 1, 5'b00100, 1, 1, 2);
      add(0, 5'b11111, 5'b11111, 1, 1, 5'b01000, 1, 1, 3);
      add(0, 5'b11111, 5'b11111, 1, 1, 5'b10000, 1, 1, 4);
      add(0, 5'b11111, 5'b11111, 1, 1, 5'b00001, 1, 1, 0);
      add(0, 5'b00010, 5'b00010, 1, 1, 5'b00010, 1, 1, 1);
      add(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 2);
      // backpressure on a 4-flit packet from port 1, port 3 waiting
      add(0, 5'b00010, 5'b00000, 1, 1, 5'b00000, 0, 0, 2);
      add(0, 5'b01010, 5'b00000, 1, 1, 5'b00010, 1, 1, 2);
      add(0, 5'b01010, 5'b00000, 0, 1, 5'b00010, 1, 0, 2);
      add(0, 5'b01010, 5'b00000, 0, 1, 5'b00010, 1, 0, 2);
      add(0, 5'b01010, 5'b00010, 0, 1, 5'b00010, 1, 0, 2);
      add(0, 5'b01010, 5'b00000, 1, 1, 5'b00010, 1, 1, 2);
      add(0, 5'b01010, 5'b00000, 1, 1, 5'b00010, 1, 1, 2);
      add(0, 5'b01010, 5'b00010, 1, 1, 5'b00010, 1, 1, 2);
      add(0, 5'b01000, 5'b01000, 1, 1, 5'b01000, 1, 1, 2);
      add(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 4);
      // owner gap: port 0 drops req for 2 cycles while port 4 waits
      add(0, 5'b00001, 5'b00000, 1, 1, 5'b00000, 0, 0, 4);
      add(0, 5'b10001, 5'b00000, 1, 1, 5'b00001, 1, 1, 4);
      add(0, 5'b10000, 5'b00000, 1, 1, 5'b00001, 1, 0, 4);
      add(0, 5'b10000, 5'b00000, 1, 1, 5'b00001, 1, 0, 4);
      add(0, 5'b10001, 5'b00001, 1, 1, 5'b00001, 1, 1, 4);
      add(0, 5'b10000, 5'b10000, 1, 1, 5'b10000, 1, 1, 1);
      add(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 0);
      // reset coinciding with port 2's tail: reset wins, ptr back to 0
      add(0, 5'b00100, 5'b00000, 1, 1, 5'b00000, 0, 0, 0);
      add(0, 5'b00100, 5'b00000, 1, 1, 5'b00100, 1, 1, 0);
      add(1, 5'b00100, 5'b00100, 1, 1, 5'b00100, 1, 1, 0);
      add(0, 5'b00110, 5'b00000, 1, 1, 5'b00000, 0, 0, 0);
      add(0, 5'b00110, 5'b00010, 1, 1, 5'b00010, 1, 1, 0);
      add(0, 5'b00100, 5'b00100, 1, 1, 5'b00100, 1, 1, 2);
      add(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 3);
      // reset mid-packet (no tail) drops the lock
      add(0, 5'b01000, 5'b00000, 1, 1, 5'b00000, 0, 0, 3);
      add(0, 5'b01000, 5'b00000, 1, 1, 5'b01000, 1, 1, 3);
      add(1, 5'b01000, 5'b00000, 1, 1, 5'b01000, 1, 1, 3);
      add(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].req, vecs[i].tail, vecs[i].ordy, vecs[i].chk,
              vecs[i].sel, vecs[i].busy, vecs[i].fire, vecs[i].ptr,
              $sformatf("row%0d", i));
      end

      // fire follows req/out_ready combinationally within a cycle
      step(0, 5'b00001, 5'b00000, 1, 1, 5'b00000, 0, 0, 0, "comb_arb");
      @(negedge clk);
      bus.req = 5'b00001; bus.tail = 5'b00000; bus.out_ready = 1'b0;
      #1 check("comb_rdy0.fire", {7'b0, bus.fire}, 8'd0);
      check("comb_rdy0.select", {3'b0, bus.select}, 8'b00001);
      bus.out_ready = 1'b1;
      #1 check("comb_rdy1.fire", {7'b0, bus.fire}, 8'd1);
      bus.req = 5'b00000;
      #1 check("comb_req0.fire", {7'b0, bus.fire}, 8'd0);
      bus.req = 5'b00001;
      #1;
      step(0, 5'b00001, 5'b00001, 1, 1, 5'b00001, 1, 1, 0, "comb_tail");
      step(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 1, "comb_idle");

      // fairness: all ports request continuously with 2-flit packets
      step(0, 5'b11111, 5'b00000, 1, 1, 5'b00000, 0, 0, 1, "fair_arb");
      for (int k = 0; k < 7; k++) begin
         p  = (1 + k) % 5;
         oh = 5'b00001 << p;
         step(0, 5'b11111, 5'b00000, 1, 1, oh, 1, 1, 3'(p), $sformatf("fair%0d_head", k));
         step(0, 5'b11111, 5'b11111, 1, 1, oh, 1, 1, 3'(p), $sformatf("fair%0d_tail", k));
      end
      step(1, 5'b00000, 5'b00000, 1, 1, 5'b01000, 1, 0, 3, "fair_rst");
      step(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 0, "fair_end");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
